regfile_dump_ctrl: RTL and testbench

- Read-side initiator for the CPU register file.
- On a start pulse it walks register addresses FIRST_REG..LAST_REG through the file's combinational read port.
- It captures each word and serializes it as bytes onto a valid/ready byte stream for the debug UART/trace path.
- It replaces simulation-only file dumps with a synthesizable register readback that works on the FPGA.

---
 rtl/regfile_dump_ctrl_if.sv | 25 ++
 rtl/regfile_dump_ctrl.sv | 151 +++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_ctrl_if.sv
// Signal bundle for regfile_dump_ctrl: dump control/status, register-file read port and byte stream.
// master = the dump controller, slave = the surrounding system (register file + byte sink).
interface regfile_dump_ctrl_if #(
  parameter int REGF_WIDTH = 32
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [4:0]            rd_addr;
  logic [REGF_WIDTH-1:0] rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [7:0]            out_byte;
  logic                  out_last;

  modport master (
    input  start, rd_data, out_ready,
    output busy, done, rd_addr, out_valid, out_byte, out_last
  );

  modport slave (
    output start, rd_data, out_ready,
    input  busy, done, rd_addr, out_valid, out_byte, out_last
  );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Register-file readback: walks FIRST_REG..LAST_REG, streams each word LSB byte first on valid/ready,
// one bubble cycle per register; stalls hold the byte. REGDUMP_CHECKSUM_EN appends an XOR checksum byte.
module regfile_dump_ctrl #(
  parameter int REGF_WIDTH = 32,
  parameter int FIRST_REG  = 0,
  parameter int LAST_REG   = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_dump_ctrl_if.master bus
);

  localparam int                NB         = REGF_WIDTH / 8;
  localparam int                IDXW       = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDXW-1:0]   LAST_IDX   = IDXW'(NB - 1);
  localparam logic [4:0]        FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0]        LAST_ADDR  = 5'(LAST_REG);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CSUM, FINISH} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, SEND, FINISH} state_t;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [4:0]            r_addr;
  logic [REGF_WIDTH-1:0] r_shift;
  logic [IDXW-1:0]       r_idx;
`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic                  w_busy;
  logic                  w_done;
  logic                  w_out_valid;
  logic [7:0]            w_out_byte;
  logic                  w_out_last;
  logic                  w_word_end;
  logic                  w_at_last;
  logic                  w_send_hs;

  assign w_word_end = (r_idx == LAST_IDX);
  assign w_at_last  = (r_addr == LAST_ADDR);
  assign w_send_hs  = (r_state == SEND) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_out_valid = 1'b0;
    w_out_byte  = 8'h00;
    w_out_last  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = FETCH;
        end
      end
      FETCH: begin
        w_busy = 1'b1;
        w_next = SEND;
      end
      SEND: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        w_out_byte  = r_shift[7:0];
`ifdef REGDUMP_CHECKSUM_EN
        w_out_last  = 1'b0;
        if (bus.out_ready && w_word_end) begin
          w_next = w_at_last ? CSUM : FETCH;
        end
`else
        w_out_last  = w_word_end && w_at_last;
        if (bus.out_ready && w_word_end) begin
          w_next = w_at_last ? FINISH : FETCH;
        end
`endif
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        w_out_byte  = r_csum;
        w_out_last  = 1'b1;
        if (bus.out_ready) begin
          w_next = FINISH;
        end
      end
`endif
      FINISH: begin
        // busy stays up through the done cycle and drops as we re-enter IDLE
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 5'd0;
      r_shift <= '0;
      r_idx   <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      r_csum  <= 8'h00;
`endif
    end else begin
      if ((r_state == IDLE) && bus.start) begin
        r_addr <= FIRST_ADDR;
`ifdef REGDUMP_CHECKSUM_EN
        r_csum <= 8'h00;
`endif
      end
      if (r_state == FETCH) begin
        r_shift <= bus.rd_data;
        r_idx   <= '0;
      end
      if (w_send_hs) begin
        r_shift <= r_shift >> 8;
        r_idx   <= r_idx + 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        r_csum  <= r_csum ^ r_shift[7:0];
`endif
        // the LAST_REG compare stops the walk, so the 5-bit address never wraps
        if (w_word_end && !w_at_last) begin
          r_addr <= r_addr + 5'd1;
        end
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.rd_addr   = r_addr;
  assign bus.out_valid = w_out_valid;
  assign bus.out_byte  = w_out_byte;
  assign bus.out_last  = w_out_last;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: full dumps (free-flowing and stalled), single-register
// instance, ignored restart, mid-dump reset, and the checksum / no-checksum tail.
module tb_regfile_dump_ctrl;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NB_TOT = 128 + CS;

  logic        clk;
  logic        rst_n;
  logic        tb_start;
  logic        tb_rdy;
  logic        sel;
  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  logic       lasts[$];
  logic [7:0] exp_q[$];
  int last_pos, last_cnt, done_cnt, done_cyc, first_hs, last_hs;
  int stall_bad, addr_bad, timeout, rst_fired;

  regfile_dump_ctrl_if #(.REGF_WIDTH(32)) bus0 ();
  regfile_dump_ctrl_if #(.REGF_WIDTH(32)) bus1 ();

  regfile_dump_ctrl #(.REGF_WIDTH(32), .FIRST_REG(0), .LAST_REG(31)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  regfile_dump_ctrl #(.REGF_WIDTH(32), .FIRST_REG(5), .LAST_REG(5)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  assign bus0.start     = tb_start;
  assign bus1.start     = tb_start;
  assign bus0.out_ready = tb_rdy;
  assign bus1.out_ready = tb_rdy;
  assign bus0.rd_data   = regs[bus0.rd_addr];
  assign bus1.rd_data   = (bus1.rd_addr == 5'd5) ? 32'hDEAD_BEEF : 32'h0;

  logic       o_valid, o_last, o_busy, o_done;
  logic [7:0] o_byte;
  logic [4:0] o_addr;
  assign o_valid = sel ? bus1.out_valid : bus0.out_valid;
  assign o_last  = sel ? bus1.out_last  : bus0.out_last;
  assign o_busy  = sel ? bus1.busy      : bus0.busy;
  assign o_done  = sel ? bus1.done      : bus0.done;
  assign o_byte  = sel ? bus1.out_byte  : bus0.out_byte;
  assign o_addr  = sel ? bus1.rd_addr   : bus0.rd_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int first, input int last, input int mode);
    logic [7:0]  x;
    logic [31:0] w;
    exp_q.delete();
    x = 8'h00;
    for (int a = first; a <= last; a++) begin
      if (mode == 1) w = (a == 5) ? 32'hDEAD_BEEF : 32'h0;
      else           w = (a == 0) ? 32'h0 : regs[a];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    if (CS != 0) exp_q.push_back(x);
  endtask

  function automatic int stream_diff();
    int n;
    n = 0;
    if (got.size() != exp_q.size()) n++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) n++;
    return n;
  endfunction

  // rdy_mode 0: always ready; 1: ready pattern 1,0,0,1. exp_addr < 0 skips the rd_addr check.
  task automatic run_dump(input int rdy_mode, input int restart_at, input int rst_at, input int exp_addr);
    logic       stalled;
    logic [7:0] hb;
    logic       hl;
    got.delete(); lasts.delete();
    last_pos = -1; last_cnt = 0; done_cnt = 0; done_cyc = -1; first_hs = -1; last_hs = -1;
    stall_bad = 0; addr_bad = 0; timeout = 0; rst_fired = 0;
    stalled = 1'b0; hb = 8'h00; hl = 1'b0;
    @(negedge clk); tb_start = 1'b1;
    @(negedge clk); tb_start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      tb_rdy   = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      tb_start = (restart_at >= 0 && got.size() == restart_at && o_valid) ? 1'b1 : 1'b0;
      if (rst_at >= 0 && got.size() == rst_at && o_valid) begin
        rst_n = 1'b0;
        #1;
        rst_fired = 1;
        break;
      end
      if (stalled && (!o_valid || o_byte !== hb || o_last !== hl)) stall_bad++;
      if (exp_addr >= 0 && o_busy && o_addr !== 5'(exp_addr)) addr_bad++;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_valid && tb_rdy) begin
        got.push_back(o_byte);
        lasts.push_back(o_last);
        if (o_last) begin
          last_cnt++;
          last_pos = got.size() - 1;
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      stalled = o_valid && !tb_rdy;
      hb = o_byte;
      hl = o_last;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    if (rst_fired == 0 && done_cyc < 0) timeout = 1;
    tb_start = 1'b0;
    // let whichever instance is still walking drain before the next step
    for (int k = 0; k < 3000 && (bus0.busy || bus1.busy); k++) begin
      tb_rdy = 1'b1;
      @(negedge clk);
    end
    tb_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tb_start = 1'b0; tb_rdy = 1'b0; sel = 1'b0;
    regs[0] = 32'h0;
    for (int k = 1; k < 32; k++) regs[k] = 32'h1000_0000 + k;

    repeat (3) @(negedge clk);
    check("rst_busy",      int'(bus0.busy), 0);
    check("rst_done",      int'(bus0.done), 0);
    check("rst_valid",     int'(bus0.out_valid), 0);
    check("rst_last",      int'(bus0.out_last), 0);
    check("rst_byte",      int'(bus0.out_byte), 0);
    check("rst_addr",      int'(bus0.rd_addr), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // free-flowing full dump
    build_exp(0, 31, 0);
    run_dump(0, -1, -1, -1);
    check("a_timeout",   timeout, 0);
    check("a_count",     got.size(), NB_TOT);
    check("a_stream",    stream_diff(), 0);
    check("a_b0",        int'(got[0]), 'h00);
    check("a_b3",        int'(got[3]), 'h00);
    check("a_b4",        int'(got[4]), 'h01);
    check("a_b5",        int'(got[5]), 'h00);
    check("a_b6",        int'(got[6]), 'h00);
    check("a_b7",        int'(got[7]), 'h10);
    check("a_b124",      int'(got[124]), 'h1F);
    check("a_b127",      int'(got[127]), 'h10);
    check("a_last_pos",  last_pos, NB_TOT - 1);
    check("a_last_cnt",  last_cnt, 1);
    check("a_done_cnt",  done_cnt, 1);
    check("a_done_gap",  done_cyc - last_hs, 1);
    check("a_first_hs",  first_hs, 1);
    check("a_span",      last_hs - first_hs, 158 + CS);
    check("a_idle_busy", int'(bus0.busy), 0);
    check("a_idle_addr", int'(bus0.rd_addr), 31);

    // stalled sink, ready 1,0,0,1
    run_dump(1, -1, -1, -1);
    check("b_timeout",   timeout, 0);
    check("b_count",     got.size(), NB_TOT);
    check("b_stream",    stream_diff(), 0);
    check("b_stall",     stall_bad, 0);
    check("b_last_pos",  last_pos, NB_TOT - 1);
    check("b_done_cnt",  done_cnt, 1);

    // single-register instance
    sel = 1'b1;
    build_exp(5, 5, 1);
    run_dump(0, -1, -1, 5);
    check("c_timeout",   timeout, 0);
    check("c_count",     got.size(), 4 + CS);
    check("c_stream",    stream_diff(), 0);
    check("c_b0",        int'(got[0]), 'hEF);
    check("c_b1",        int'(got[1]), 'hBE);
    check("c_b2",        int'(got[2]), 'hAD);
    check("c_b3",        int'(got[3]), 'hDE);
    check("c_last_pos",  last_pos, 3 + CS);
    check("c_addr",      addr_bad, 0);
    check("c_done_cnt",  done_cnt, 1);
    sel = 1'b0;

    // start re-pulsed at byte 40 is ignored
    build_exp(0, 31, 0);
    run_dump(0, 40, -1, -1);
    check("d_count",     got.size(), NB_TOT);
    check("d_stream",    stream_diff(), 0);
    check("d_done_cnt",  done_cnt, 1);

    // reset at byte 60
    run_dump(0, -1, 60, -1);
    check("e_fired",     rst_fired, 1);
    check("e_valid",     int'(bus0.out_valid), 0);
    check("e_busy",      int'(bus0.busy), 0);
    check("e_addr",      int'(bus0.rd_addr), 0);
    check("e_done",      int'(bus0.done), 0);
    check("e_count",     got.size(), 60);
    check("e_last_cnt",  last_cnt, 0);
    check("e_done_cnt",  done_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_dump(0, -1, -1, -1);
    check("e2_count",    got.size(), NB_TOT);
    check("e2_stream",   stream_diff(), 0);
    check("e2_done_cnt", done_cnt, 1);

    // tail: reg[1]=FF, everything else 0
    for (int k = 0; k < 32; k++) regs[k] = 32'h0;
    regs[1] = 32'h0000_00FF;
    build_exp(0, 31, 0);
    run_dump(0, -1, -1, -1);
    check("f_count",     got.size(), NB_TOT);
    check("f_stream",    stream_diff(), 0);
    check("f_b4",        int'(got[4]), 'hFF);
    check("f_final",     int'(got[NB_TOT - 1]), (CS != 0) ? 'hFF : 'h00);
    check("f_last_pos",  last_pos, NB_TOT - 1);
    check("f_last_127",  int'(lasts[127]), (CS != 0) ? 0 : 1);
    check("f_last_cnt",  last_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
